soc_boot_copier: RTL and testbench

SOC_BOOT_COPIER -- requirements
Module: soc_boot_copier

---
 rtl/soc_boot_copier.sv | 171 +++++++++++++++++
 tb/tb_soc_boot_copier.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_boot_copier.sv
// Boot copier: Wishbone master that copies WORDS 32-bit words from boot ROM to RAM,
// holding the CPU in reset until the copy succeeds.
module soc_boot_copier #(
    parameter int          AW       = 32,
    parameter int          DW       = 32,
    parameter logic [31:0] SRC_BASE = 32'h0000_0000,
    parameter logic [31:0] DST_BASE = 32'h0000_1000,
    parameter int          WORDS    = 64,
    parameter int          TIMEOUT  = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          error_o,
    output logic          cpu_rst_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [AW-1:0] SRC_A    = AW'(SRC_BASE);
    localparam logic [AW-1:0] DST_A    = AW'(DST_BASE);
    localparam logic [15:0]   LAST_IDX = 16'(WORDS - 1);
    localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT - 1);

    logic [2:0]    state_q, state_d;
    logic [15:0]   idx_q, idx_d;
    logic [15:0]   tmo_q, tmo_d;
    logic          start_q, start_d;
    logic          arm_q, arm_d;
    logic          stb_q, stb_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          cpu_rst_q, cpu_rst_d;

    function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] base, input logic [15:0] i);
        return base + (AW'(i) << 2);
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        start_d = start_i;
        // arm_q keeps a start level held across reset release from looking like an edge
        arm_d   = 1'b1;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;

        case (state_q)
            S_IDLE: begin
                if (arm_q && start_i && !start_q) begin
                    state_d = S_READ;
                    idx_d   = 16'd0;
                    tmo_d   = 16'd0;
                    stb_d   = 1'b1;
                    we_d    = 1'b0;
                    adr_d   = word_addr(SRC_A, 16'd0);
                end
            end
            S_READ, S_WRITE: begin
                if (stb_q) begin
                    if (wb_err_i || wb_rty_i) begin
                        stb_d   = 1'b0;
                        state_d = S_ERROR;
                    end else if (wb_ack_i) begin
                        stb_d = 1'b0;
                        if (state_q == S_READ) dat_d = wb_dat_i;
                    end else if (tmo_q == TMO_LAST) begin
                        stb_d   = 1'b0;
                        state_d = S_ERROR;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end else begin
                    // stb low inside READ/WRITE is the mandatory idle cycle after an ack
                    tmo_d = 16'd0;
                    if (state_q == S_READ) begin
                        state_d = S_WRITE;
                        stb_d   = 1'b1;
                        we_d    = 1'b1;
                        adr_d   = word_addr(DST_A, idx_q);
                    end else if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                        idx_d   = idx_q + 16'd1;
                        stb_d   = 1'b1;
                        we_d    = 1'b0;
                        adr_d   = word_addr(SRC_A, idx_q + 16'd1);
                    end
                end
            end
            default: ;
        endcase

        sel_d     = stb_d ? 4'hF : 4'h0;
        busy_d    = (state_d == S_READ) || (state_d == S_WRITE);
        done_d    = (state_d == S_DONE);
        err_d     = (state_d == S_ERROR);
        cpu_rst_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            tmo_q     <= '0;
            start_q   <= 1'b0;
            arm_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= 4'h0;
            adr_q     <= '0;
            dat_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            start_q   <= start_d;
            arm_q     <= arm_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;
    assign wb_we_o   = we_q;
    assign wb_cyc_o  = stb_q;
    assign wb_stb_o  = stb_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign error_o   = err_q;
    assign cpu_rst_o = cpu_rst_q;

endmodule

// File: tb/tb_soc_boot_copier.sv
// Bench for soc_boot_copier: ROM/RAM slave model with selectable response behaviour,
// per-cycle scoreboard of the bus and status outputs, and directed scenario checks.
module tb_soc_boot_copier;

    localparam int          WORDS = 4;
    localparam int          TMO   = 8;
    localparam logic [31:0] SRC   = 32'h0000_0000;
    localparam logic [31:0] DST   = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i;
    logic        busy_o, done_o, error_o, cpu_rst_o;

    // 0: ack same cycle as stb, 1: registered pulse ack, 2: never respond,
    // 3: err on the third read, 4: ack held high permanently
    int   mode = 0;
    logic pack = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    // scoreboard state
    int          reads_acked, writes_acked, run;
    bit          started, prev_resp, fault_seen;
    logic [31:0] wr_adr_q[$];
    logic [31:0] wr_dat_q[$];

    soc_boot_copier #(
        .AW(32), .DW(32), .SRC_BASE(SRC), .DST_BASE(DST), .WORDS(WORDS), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .cpu_rst_o(cpu_rst_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pack <= (mode == 1) ? (wb_stb_o & ~pack) : 1'b0;

    always_comb begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        case (mode)
            0: wb_ack_i = wb_stb_o;
            1: wb_ack_i = pack;
            3: begin
                if (wb_stb_o && !wb_we_o && wb_adr_o == SRC + 32'd8) wb_err_i = 1'b1;
                else wb_ack_i = wb_stb_o;
            end
            4: wb_ack_i = 1'b1;
            default: ;
        endcase
        wb_dat_i = 32'hA5A5_0000 + ((wb_adr_o - SRC) >> 2);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the transfer model
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                reads_acked = 0; writes_acked = 0; run = 0;
                started = 0; prev_resp = 0; fault_seen = 0;
                wr_adr_q.delete(); wr_dat_q.delete();
            end else begin
                if (wb_stb_o) started = 1;
                check("cyc_eq_stb", {31'd0, wb_cyc_o}, {31'd0, wb_stb_o});
                check("cpu_rst_vs_done", {31'd0, cpu_rst_o}, {31'd0, ~done_o});
                check("busy", {31'd0, busy_o}, {31'd0, started && !done_o && !error_o});
                if (done_o) check("done_word_count", writes_acked, WORDS);
                if (done_o || error_o) check("stb_after_end", {31'd0, wb_stb_o}, 32'd0);
                if (error_o) check("error_cause", {31'd0, fault_seen}, 32'd1);
                if (prev_resp) check("stb_gap", {31'd0, wb_stb_o}, 32'd0);
                if (wb_stb_o) begin
                    check("sel", {28'd0, wb_sel_o}, 32'hF);
                    if (wb_we_o) begin
                        check("wr_adr", wb_adr_o, DST + 32'(4 * writes_acked));
                        check("wr_dat", wb_dat_o, 32'hA5A5_0000 + 32'(writes_acked));
                        check("wr_after_rd", reads_acked, writes_acked + 1);
                    end else begin
                        check("rd_adr", wb_adr_o, SRC + 32'(4 * reads_acked));
                        check("rd_order", reads_acked, writes_acked);
                    end
                    run++;
                    check("stb_run_le_timeout", {31'd0, run <= TMO}, 32'd1);
                end else begin
                    run = 0;
                end
                prev_resp = wb_stb_o && (wb_ack_i || wb_err_i || wb_rty_i);
                if (wb_stb_o && (wb_err_i || wb_rty_i)) fault_seen = 1;
                else if (wb_stb_o && wb_ack_i) begin
                    if (wb_we_o) begin
                        wr_adr_q.push_back(wb_adr_o);
                        wr_dat_q.push_back(wb_dat_o);
                        writes_acked++;
                    end else begin
                        reads_acked++;
                    end
                end else if (wb_stb_o && run == TMO) fault_seen = 1;
            end
        end
    end

    task automatic do_reset(input logic start_lvl);
        @(negedge clk);
        rst = 1'b1;
        start_i = start_lvl;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Cycles (negedges) until the chosen output goes high; -1 if the budget runs out
    task automatic wait_out(input string name, input int which, input int limit, output int cycles);
        logic v;
        cycles = 0;
        forever begin
            @(negedge clk);
            cycles++;
            v = (which == 0) ? wb_stb_o : (which == 1) ? done_o : error_o;
            if (v) break;
            if (cycles >= limit) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s: no response within %0d cycles", name, limit);
                cycles = -1;
                break;
            end
        end
    endtask

    task automatic quiet(input string name, input int n);
        int cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (wb_stb_o || wb_cyc_o || busy_o) cnt++;
        end
        check(name, cnt, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        start_i = 1'b1;
    endtask

    task automatic check_writes(input string name, input int n);
        check({name, "_count"}, wr_adr_q.size(), n);
        for (int i = 0; i < n && i < wr_adr_q.size(); i++) begin
            check({name, "_adr"}, wr_adr_q[i], DST + 32'(4 * i));
            check({name, "_dat"}, wr_dat_q[i], 32'hA5A5_0000 + 32'(i));
        end
    endtask

    initial begin
        int c;
        // reset values while rst is high
        #12;
        check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        check("rst_we", {31'd0, wb_we_o}, 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        check("rst_status", {28'd0, busy_o, done_o, error_o, cpu_rst_o}, 32'b0001);

        // copy with same-cycle ack: done 16 cycles after first stb
        mode = 0;
        do_reset(1'b0);
        pulse_start();
        wait_out("copy_first_stb", 0, 10, c);
        check("copy_first_stb_delay", c, 1);
        check("copy_first_adr", wb_adr_o, 32'h0000_0000);
        wait_out("copy_done", 1, 100, c);
        check("copy_done_latency", c, 16);
        check("copy_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
        check("copy_w2_literal", wr_dat_q.size() > 2 ? wr_dat_q[2] : 32'hx, 32'hA5A5_0002);
        check("copy_a3_literal", wr_adr_q.size() > 3 ? wr_adr_q[3] : 32'hx, 32'h0000_100C);
        check_writes("copy", 4);
        // a retrigger in DONE is ignored
        pulse_start();
        quiet("retrigger_in_done", 12);
        check("done_held", {31'd0, done_o}, 32'd1);

        // registered single-pulse ack slave
        mode = 1;
        do_reset(1'b0);
        pulse_start();
        wait_out("pulse_done", 1, 200, c);
        check_writes("pulse", 4);

        // err on the third read
        mode = 3;
        do_reset(1'b0);
        pulse_start();
        wait_out("err_seen", 2, 200, c);
        check("err_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        check("err_done", {31'd0, done_o}, 32'd0);
        check_writes("err", 2);
        quiet("err_no_more_stb", 10);

        // slave never answers
        mode = 2;
        do_reset(1'b0);
        pulse_start();
        wait_out("tmo_first_stb", 0, 10, c);
        wait_out("tmo_error", 2, 50, c);
        check("tmo_latency", c, 8);
        check("tmo_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("tmo_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);

        // reset during the second write, with ack held high throughout
        mode = 4;
        do_reset(1'b0);
        pulse_start();
        c = 0;
        while (!(wb_stb_o && wb_we_o && wb_adr_o == DST + 32'd4) && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("abort_reached_w2", {31'd0, c < 100}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("abort_stb", {31'd0, wb_stb_o}, 32'd0);
        check("abort_adr", wb_adr_o, 32'd0);
        check("abort_status", {28'd0, busy_o, done_o, error_o, cpu_rst_o}, 32'b0001);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        quiet("abort_no_resume", 10);
        pulse_start();
        wait_out("abort_restart_stb", 0, 10, c);
        check("abort_restart_adr", wb_adr_o, SRC);
        wait_out("abort_restart_done", 1, 100, c);
        check_writes("abort_restart", 4);

        // start held high through reset release does nothing
        mode = 0;
        do_reset(1'b1);
        quiet("start_level_ignored", 12);
        pulse_start();
        wait_out("level_then_edge_done", 1, 100, c);
        check_writes("level_then_edge", 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
